// File: rtl/prng_trivium_bank.sv
// Bank of Trivium keystream generators, 64 steps per cycle per instance.
// Optional rekey request counter enabled by defining PRNG_REKEY_REQ_EN.
module prng_trivium_bank #(
  parameter int RND        = 64,
  parameter int REKEY_LOG2 = 20
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start_reseed,
  input  logic [79:0]    seed,
  input  logic           en,
  output logic [RND-1:0] rnd_out,
  output logic           out_valid,
  output logic           reseed_req
);

  localparam int NINST = (RND + 63) / 64;
  localparam int KW    = 64 * NINST;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  state_t        st;
  state_t        st_nxt;
  logic [4:0]    wcnt;
  logic          load;
  logic          adv;
  logic          cap;
  logic [KW-1:0] ks;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (1'b1)
      start_reseed: st_nxt = WARMUP;
      !start_reseed && (st == WARMUP) && (wcnt == 5'd17):
        st_nxt = RUN;
      default: ;
    endcase
  end

  // Reseed overrides both warm-up and keystream output at the same edge
  always_comb begin
    load = start_reseed;
    adv  = !start_reseed &&
           ((st == WARMUP) || ((st == RUN) && en));
    cap  = !start_reseed && (st == RUN) && en;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcnt <= '0;
    end else if (load) begin
      wcnt <= '0;
    end else if (st == WARMUP) begin
      wcnt <= wcnt + 5'd1;
    end
  end

  for (genvar i = 0; i < NINST; i++) begin : g_inst
    logic [287:0] s_q;
    logic [287:0] s_c;
    logic [63:0]  z_c;
    logic         t1;
    logic         t2;
    logic         t3;

    always_comb begin
      s_c = s_q;
      z_c = '0;
      t1  = 1'b0;
      t2  = 1'b0;
      t3  = 1'b0;
      for (int k = 0; k < 64; k++) begin
        t1     = s_c[65] ^ s_c[92];
        t2     = s_c[161] ^ s_c[176];
        t3     = s_c[242] ^ s_c[287];
        z_c[k] = t1 ^ t2 ^ t3;
        t1     = t1 ^ (s_c[90] & s_c[91]) ^ s_c[170];
        t2     = t2 ^ (s_c[174] & s_c[175]) ^ s_c[263];
        t3     = t3 ^ (s_c[285] & s_c[286]) ^ s_c[68];
        s_c    = {s_c[286:177], t2, s_c[175:93], t1,
                  s_c[91:0], t3};
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        s_q <= '0;
      end else if (load) begin
        s_q <= {3'b111, 112'd0, 80'(i), 13'd0, seed};
      end else if (adv) begin
        s_q <= s_c;
      end
    end

    assign ks[64*i +: 64] = z_c;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rnd_out   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b0;
    end else if (cap) begin
      rnd_out   <= ks[RND-1:0];
      out_valid <= 1'b1;
    end
  end

`ifdef PRNG_REKEY_REQ_EN
  logic [REKEY_LOG2-1:0] rk_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rk_cnt     <= '0;
      reseed_req <= 1'b0;
    end else if (load) begin
      rk_cnt     <= '0;
      reseed_req <= 1'b0;
    end else if (cap) begin
      rk_cnt <= rk_cnt + REKEY_LOG2'(1);
      if (&rk_cnt) begin
        reseed_req <= 1'b1;
      end
    end
  end
`else
  assign reseed_req = (REKEY_LOG2 < 0);
`endif

endmodule
